fc_match_store: RTL



---
 rtl/cues_fc_pkg.sv | 44 ++++
 rtl/fc_match_ram.sv | 45 ++++
 rtl/fc_match_store.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cues_fc_pkg.sv
// Shared types and constants for the CUES firing-control operand-matching path.
// Action codes, field widths and the matching-store entry layout live here.
package cues_fc_pkg;

    localparam logic [1:0] MW_NONE  = 2'b00;
    localparam logic [1:0] MW_FIRE  = 2'b01;
    localparam logic [1:0] MW_STORE = 2'b10;
    localparam logic [1:0] MW_DUP   = 2'b11;

    localparam int NODE_W = 32'd16;
    localparam int GEN_W  = 32'd12;
    localparam int OPR_W  = 32'd32;

    typedef struct packed {
        logic [NODE_W-1:0] node;
        logic [GEN_W-1:0]  gen;
        logic              lr;
        logic [OPR_W-1:0]  opr;
    } fc_data_t;

    typedef struct packed {
        logic     valid;
        fc_data_t data;
    } fc_entry_t;

    // Classify a lookup: empty slot stores, foreign tag recirculates,
    // same tag fires on opposite side or is a duplicate on the same side.
    function automatic logic [1:0] fc_action(input logic valid,
                                             input logic tag_eq,
                                             input logic lr_eq);
        logic [1:0] act;
        if (!valid) begin
            act = MW_STORE;
        end else if (!tag_eq) begin
            act = MW_NONE;
        end else if (lr_eq) begin
            act = MW_DUP;
        end else begin
            act = MW_FIRE;
        end
        return act;
    endfunction

endpackage

// File: rtl/fc_match_ram.sv
// Direct-mapped matching-store array: combinational read, single write port,
// and a one-cycle parallel clear of every valid bit.
module fc_match_ram
    import cues_fc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [IDX_W-1:0] raddr,
    output fc_entry_t        rdata,
    input  logic             wen,
    input  logic [IDX_W-1:0] waddr,
    input  fc_entry_t        wdata
);

    logic [DEPTH-1:0] valid_r;
    fc_data_t         data_r [DEPTH];

    assign rdata.valid = valid_r[raddr];
    assign rdata.data  = data_r[raddr];

    // Valid bits: reset and flush clear all entries at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
        end else if (flush) begin
            valid_r <= '0;
        end else if (wen) begin
            valid_r[waddr] <= wdata.valid;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Payloads carry no reset; they are only meaningful behind a valid bit.
    always_ff @(posedge clk) begin
        if (wen) begin
            data_r[waddr] <= wdata.data;
        end
    end

endmodule

// File: rtl/fc_match_store.sv
// Operand-matching stage ahead of FC1: looks up a waiting partner per token
// and emits one registered beat per accepted token with its action code.
module fc_match_store
    import cues_fc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_lr_i,
    input  logic [NODE_W-1:0] in_node_i,
    input  logic [GEN_W-1:0]  in_gen_i,
    input  logic [OPR_W-1:0]  in_opr_i,
    input  logic              flush_i,
    output logic              lr_o,
    output logic [NODE_W-1:0] node_o,
    output logic [GEN_W-1:0]  gen_o,
    output logic [OPR_W-1:0]  opr_o,
    output logic [1:0]        mem_wen_o,
    output logic [OPR_W-1:0]  mtch_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [IDX_W:0]    occ_o
);

    logic [IDX_W-1:0]  idx_s;
    fc_entry_t         rd_s;
    fc_entry_t         wdata_s;
    logic              wen_s;
    logic              accept_s;
    logic [1:0]        action_s;
    logic [OPR_W-1:0]  mtch_s;
    logic [IDX_W:0]    occ_next_s;

    logic              lr_r;
    logic [NODE_W-1:0] node_r;
    logic [GEN_W-1:0]  gen_r;
    logic [OPR_W-1:0]  opr_r;
    logic [1:0]        mem_wen_r;
    logic [OPR_W-1:0]  mtch_r;
    logic              out_valid_r;
    logic [IDX_W:0]    occ_r;

    // XOR folding spreads consecutive generations of one node across entries.
    assign idx_s      = in_node_i[IDX_W-1:0] ^ in_gen_i[IDX_W-1:0];
    assign in_ready_o = !flush_i && (!out_valid_r || out_ready_i);
    assign accept_s   = in_valid_i && in_ready_o;

    fc_match_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_i),
        .raddr (idx_s),
        .rdata (rd_s),
        .wen   (wen_s),
        .waddr (idx_s),
        .wdata (wdata_s)
    );

    // Action decode and store write-back for the token being accepted.
    always_comb begin
        action_s   = fc_action(rd_s.valid,
                               (rd_s.data.node == in_node_i) && (rd_s.data.gen == in_gen_i),
                               rd_s.data.lr == in_lr_i);
        wen_s      = 1'b0;
        wdata_s    = '0;
        mtch_s     = '0;
        occ_next_s = occ_r;
        if (accept_s) begin
            case (action_s)
                MW_FIRE: begin
                    wen_s         = 1'b1;
                    wdata_s.valid = 1'b0;
                    wdata_s.data  = rd_s.data;
                    mtch_s        = rd_s.data.opr;
                    occ_next_s    = occ_r - {{IDX_W{1'b0}}, 1'b1};
                end
                MW_STORE: begin
                    wen_s         = 1'b1;
                    wdata_s.valid = 1'b1;
                    wdata_s.data  = '{node: in_node_i, gen: in_gen_i,
                                      lr: in_lr_i, opr: in_opr_i};
                    occ_next_s    = occ_r + {{IDX_W{1'b0}}, 1'b1};
                end
                default: begin
                    wen_s = 1'b0;
                end
            endcase
        end else begin
            wen_s = 1'b0;
        end
    end

    // Output beat register; fields hold while the beat waits downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            lr_r        <= 1'b0;
            node_r      <= '0;
            gen_r       <= '0;
            opr_r       <= '0;
            mem_wen_r   <= MW_NONE;
            mtch_r      <= '0;
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            lr_r        <= in_lr_i;
            node_r      <= in_node_i;
            gen_r       <= in_gen_i;
            opr_r       <= in_opr_i;
            mem_wen_r   <= action_s;
            mtch_r      <= mtch_s;
            out_valid_r <= 1'b1;
        end else if (out_ready_i) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Occupancy tracks valid entries; flush empties the store in one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_r <= '0;
        end else if (flush_i) begin
            occ_r <= '0;
        end else begin
            occ_r <= occ_next_s;
        end
    end

    assign lr_o        = lr_r;
    assign node_o      = node_r;
    assign gen_o       = gen_r;
    assign opr_o       = opr_r;
    assign mem_wen_o   = mem_wen_r;
    assign mtch_data_o = mtch_r;
    assign out_valid_o = out_valid_r;
    assign occ_o       = occ_r;

endmodule
